pmem_arbiter_adaptor: RTL
=========================

// Module: pmem_arbiter_adaptor
// PURPOSE
//   Sits between the L1 icache/dcache and the 64-bit burst physical-memory port of mp4.
//   Arbitrates 256-bit line requests from both caches onto one pmem port.
//   Converts each line transfer into a 4-beat x 64-bit burst and returns a full line to the winner.
// PARAMETERS
//   ADDR_W   32   byte-address width
//   LINE_W   256  cache line width (bits)
//   BEAT_W   64   pmem data width; BEATS = LINE_W/BEAT_W = 4
// PORTS
//   clk           in   1       system clock
//   rst           in   1       asynchronous reset, active-high
//   i_read        in   1       icache line read request
//   i_address     in   ADDR_W  icache line address (low 5 bits ignored)
//   i_rdata       out  LINE_W  line returned to icache
//   i_resp        out  1       icache transfer complete, 1-cycle pulse
//   d_read        in   1       dcache line read request
//   d_write       in   1       dcache line writeback request
//   d_address     in   ADDR_W  dcache line address (low 5 bits ignored)
//   d_wdata       in   LINE_W  dcache writeback line
//   d_rdata       out  LINE_W  line returned to dcache
//   d_resp        out  1       dcache transfer complete, 1-cycle pulse
//   pmem_read     out  1       burst read, held until 4th pmem_resp
//   pmem_write    out  1       burst write, held until 4th pmem_resp
//   pmem_address  out  ADDR_W  line-aligned address ({addr[31:5],5'b0})
//   pmem_wdata    out  BEAT_W  current write beat
//   pmem_rdata    in   BEAT_W  current read beat
//   pmem_resp     in   1       beat accepted/valid
// BEHAVIOUR
//   - Reset: state=IDLE, beat counter=0, all outputs 0 (line buffers cleared to 0).
//     Async assert mid-burst abandons the transfer; no client resp is issued.
//   - FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
//   - IDLE: samples requests each cycle.
//     Grant priority: d_write > d_read > i_read.
//     d_read && d_write both high is treated as a write.
//     On grant, latch address (and d_wdata for writes) and enter the burst state next cycle.
//     pmem_read/pmem_write therefore rise exactly 1 cycle after the request is first seen.
//   - I_RD/D_RD: pmem_read=1.
//     Each pmem_resp stores pmem_rdata into line_buf[64*cnt +: 64], then cnt++.
//     On the 4th resp (cnt==3) go to DONE; pmem_read drops the cycle after that resp.
//   - D_WR: pmem_write=1, pmem_wdata = wline[64*cnt +: 64] (beat 0 = bits 63:0).
//     cnt++ on each pmem_resp; on the 4th resp go to DONE.
//   - DONE: the granted client's resp=1 for exactly one cycle.
//     Its rdata holds line_buf (held stable until that client's next resp).
//     Next state is IDLE; cnt resets to 0.
//   - Clients must deassert their request in the cycle resp is high.
//     Requests are not re-sampled during DONE, so back-to-back requests cost 1 IDLE cycle.
//   - Minimum transaction latency: request -> resp = 1 (grant) + 4 beats + 1 (DONE) = 6 cycles.
//   - pmem_resp while IDLE or DONE is ignored.
//     Requests arriving mid-burst wait; the losing client is never dropped.
//   - Client inputs are not re-sampled mid-burst; changes to address/wdata after grant have no effect.
//   - cnt is 2 bits and wraps only via the DONE reset, never mid-burst.
// CONFIGURATION
//   PMEM_ARB_RR_EN defined: when both i_read and a dcache request are pending in IDLE,
//     the client NOT granted last wins (1-bit last_grant flop, reset to icache, so dcache wins the first tie).
//     The write>read order within dcache is unchanged.
//   Undefined: fixed priority as above; icache can starve under continuous dcache traffic.
// TESTING
//   1. i_read=1, i_address=0x0000_0064; pmem_rdata beats 0x11..,0x22..,0x33..,0x44.. ->
//      pmem_address=0x0000_0060; i_rdata={0x44..,0x33..,0x22..,0x11..}; i_resp 1 cycle, 6 cycles after request.
//   2. d_write=1, d_address=0x8000_0020, d_wdata=256'h{D,C,B,A} ->
//      pmem_write=1 with pmem_wdata A,B,C,D on successive resps; d_resp pulse; pmem_read never asserted.
//   3. i_read and d_read raised in the same cycle, macro undefined ->
//      dcache burst first, d_resp; icache burst starts 1 IDLE cycle later, then i_resp.
//   4. Same as 3 with PMEM_ARB_RR_EN, repeated twice ->
//      grants D,I then I,D alternate; neither client waits more than one transaction.
//   5. rst asserted after the 2nd beat of a read ->
//      pmem_read=0 immediately, no resp; after release a fresh i_read completes normally with cnt from 0.
//   6. pmem_resp pulsed while IDLE with no requests ->
//      no state change, no client resp, pmem_read/write stay 0.

Source files
------------

// File: rtl/pmem_arbiter_adaptor.sv
// Arbitrates icache/dcache line requests onto one 64-bit burst pmem port, 4 beats per line.
// Build option: define PMEM_ARB_RR_EN for round-robin icache/dcache tie-breaking.
module pmem_arbiter_adaptor #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [1:0]  LastBeat = 2'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_W-OFF_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]       wline_q, wline_d;
  logic [LINE_W-1:0]       line_buf_q, line_buf_d;
  logic [LINE_W-1:0]       i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]       d_rdata_q, d_rdata_d;
  logic                    grant_d_q, grant_d_d;  // DONE answers dcache when set
  logic                    d_req, pick_d;
  int unsigned             beat_lsb;

  // Line offset bits are never used; the port is always line-aligned.
  logic unused_offset;
  assign unused_offset = ^{i_address[OFF_W-1:0], d_address[OFF_W-1:0]};

  assign d_req    = d_read | d_write;
  assign beat_lsb = BEAT_W * cnt_q;

`ifdef PMEM_ARB_RR_EN
  logic last_d_q, last_d_d;  // winner of the last contested grant, 0 = icache

  // A tie goes to whichever client did not win the previous tie.
  assign pick_d = d_req & (~i_read | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == StIdle && d_req && i_read) begin
      last_d_d = pick_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    line_buf_d = line_buf_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_d_d  = grant_d_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_d) begin
          grant_d_d = 1'b1;
          addr_d    = d_address[ADDR_W-1:OFF_W];
          if (d_write) begin
            wline_d = d_wdata;
            state_d = StDWr;
          end else begin
            state_d = StDRd;
          end
        end else if (i_read) begin
          grant_d_d = 1'b0;
          addr_d    = i_address[ADDR_W-1:OFF_W];
          state_d   = StIRd;
        end
      end
      StIRd, StDRd: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          line_buf_d[beat_lsb +: BEAT_W] = pmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastBeat) begin
            state_d = StDone;
            if (state_q == StIRd) begin
              i_rdata_d = line_buf_d;
            end else begin
              d_rdata_d = line_buf_d;
            end
          end
        end
      end
      StDWr: begin
        pmem_write = 1'b1;
        pmem_wdata = wline_q[beat_lsb +: BEAT_W];
        if (pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastBeat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        i_resp  = ~grant_d_q;
        d_resp  = grant_d_q;
        cnt_d   = 2'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      wline_q    <= '0;
      line_buf_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      grant_d_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wline_q    <= wline_d;
      line_buf_q <= line_buf_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      grant_d_q  <= grant_d_d;
    end
  end

  assign pmem_address = {addr_q, {OFF_W{1'b0}}};
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule
